// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store adapter in front of a word-only data memory.
// Sub-word stores run as a two-cycle read-modify-write; misaligned accesses are suppressed and counted.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] Store_Data,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic [DATA_WIDTH-1:0] Load_Data,
    output logic                  Stall,
    output logic                  Misaligned,
    output logic [CNT_WIDTH-1:0]  Misaligned_Count,
    output logic [DATA_WIDTH-1:0] Mem_Address,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data,
    output logic                  Mem_Read,
    output logic                  Mem_Write,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data
);

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] merge_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  access;
    logic                  mis_access;
    logic                  sub_store;
    logic [DATA_WIDTH-1:0] word_addr;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic [3:0]            lane_en;
    logic [DATA_WIDTH-1:0] st_rep;
    logic [DATA_WIDTH-1:0] merged;

    assign access     = MemRead | MemWrite;
    assign mis_access = access && (state_q == StIdle) &&
                        (((Size == 2'b01) && Addr[0]) || (Size[1] && (Addr[1:0] != 2'b00)));
    assign sub_store  = MemWrite && !Size[1];
    assign word_addr  = {2'b00, Addr[DATA_WIDTH-1:2]};

    assign ld_byte = Mem_Read_Data[{Addr[1:0], 3'b000} +: 8];
    assign ld_half = Addr[1] ? Mem_Read_Data[31:16] : Mem_Read_Data[15:0];

    always_comb begin
        ld_ext = Mem_Read_Data;
        if (Size == 2'b00) begin
            ld_ext = Unsigned ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                              : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
        end else if (Size == 2'b01) begin
            ld_ext = Unsigned ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                              : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
        end
    end

    // Replicate the store operand across all lanes, then pick lanes by enable.
    always_comb begin
        lane_en = 4'b0000;
        st_rep  = {2{Store_Data[15:0]}};
        if (Size == 2'b00) begin
            lane_en = 4'b0001 << Addr[1:0];
            st_rep  = {4{Store_Data[7:0]}};
        end else begin
            lane_en = Addr[1] ? 4'b1100 : 4'b0011;
        end
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = lane_en[i] ? st_rep[i*8 +: 8] : Mem_Read_Data[i*8 +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            merge_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mis_access) begin
                        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
                    end else if (sub_store) begin
                        merge_q <= merged;
                        addr_q  <= word_addr;
                        state_q <= StRmwWr;
                    end
                end
                StRmwWr: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Misaligned_Count = cnt_q;

    always_comb begin
        Load_Data      = '0;
        Stall          = 1'b0;
        Misaligned     = 1'b0;
        Mem_Address    = '0;
        Mem_Write_Data = '0;
        Mem_Read       = 1'b0;
        Mem_Write      = 1'b0;
        if (RST) begin
            if (state_q == StRmwWr) begin
                Mem_Write      = 1'b1;
                Mem_Address    = addr_q;
                Mem_Write_Data = merge_q;
            end else begin
                Mem_Address = word_addr;
                Misaligned  = mis_access;
                if (!mis_access) begin
                    if (MemWrite && Size[1]) begin
                        Mem_Write      = 1'b1;
                        Mem_Write_Data = Store_Data;
                    end else if (MemWrite) begin
                        Mem_Read = 1'b1;
                        Stall    = 1'b1;
                    end else if (MemRead) begin
                        Mem_Read  = 1'b1;
                        Load_Data = ld_ext;
                    end
                end
            end
        end
    end

endmodule
